ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It is the parametrised successor to the team's single-digit hex decoder. It latches a packed hex value on a load strobe and scans the digits at a programmable refresh rate, with anti-ghosting blanking, optional leading-zero suppression and per-digit decimal points. It sits between the datapath (counters, ALU results) and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  scan enable; when low, the display is dark and the timer is frozen.
- load  input  1  single-cycle strobe that latches value, dp_in and blank_lz.
- value  input  4*NUM_DIGITS  packed nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit (1 = lit).
- blank_lz  input  1  leading-zero suppression request.
- seg_n  output  7  segment drive, active-low; bit6 = g … bit0 = a.
- dp_n  output  1  decimal-point drive, active-low.
- an_n  output  NUM_DIGITS  anode select, active-low, one-hot-cold when a digit is lit.
- frame_done  output  1  one-cycle pulse at the end of each full scan frame.

## Operation
- Shadow registers: val_q, dp_q and lz_q load from value, dp_in and blank_lz on any cycle with load=1. The shadow registers load independently of enable.
- Scan timer: a prescaler counts 0..REFRESH_DIV-1 while enable=1.
  - At the terminal count, the prescaler returns to 0 and the digit index idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- frame_done=1 for exactly the cycle where prescaler = REFRESH_DIV-1 and idx = NUM_DIGITS-1, with enable=1.
- Font (active-low, hex): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, B=03h, C=46h, D=21h, E=06h, F=0Eh.
- Leading-zero blank: digit i (i>0) is blank when lz_q=1 and every nibble at index ≥ i is 0. Digit 0 is never blanked, so value 0 shows a single "0".
- A blanked digit drives seg_n=7Fh, while dp_n still follows dp_q[i].
- Ghost blanking: while prescaler < BLANK_CYCLES, an_n is all-ones and seg_n=7Fh.
- When enable=0: an_n is all-ones, seg_n=7Fh, dp_n=1, frame_done=0, and the prescaler and idx hold their values. Scanning resumes from the held state.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values:
  - prescaler=0, idx=0, val_q=0, dp_q=0, lz_q=0.
  - seg_n=7Fh, dp_n=1, an_n all-ones, frame_done=0.
- Output latency: outputs reflect the prescaler, idx and shadow state of the previous cycle.
  - A load on cycle t is visible on the pins at t+2, provided the digit is lit.
- Slot length: each digit is lit for REFRESH_DIV-BLANK_CYCLES cycles per slot.
- Frame length: NUM_DIGITS*REFRESH_DIV cycles.
- load coinciding with a slot boundary: the new shadow value applies; there is no mixed-nibble slot.
- Reset asserted mid-scan: all outputs go to their reset values asynchronously, and no frame_done is emitted.
- NUM_DIGITS=1: idx is constant 0, and frame_done fires at every terminal count.

## Structure
- Package ssd_pkg holds:
  - the 16-entry font constant array and the function hex_to_seg(nibble) returning 7 bits;
  - the constant SEG_BLANK = 7'h7F.
- Sub-module ssd_scan_timer (parameters NUM_DIGITS and REFRESH_DIV) owns the prescaler, idx and frame_done logic.
- The top level owns the shadow registers, blanking and font lookup, and the output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: hold rst_n=0 with random inputs -> seg_n=7Fh, dp_n=1, an_n=Fh, frame_done=0; after release with enable=1, the first lit slot is an_n=Eh.
- Scan: load value=1234h, blank_lz=0 -> an_n sequence E,D,B,7; seg_n sequence 19h,30h,24h,79h; each digit lit 3 cycles after 1 dark cycle; frame_done pulses every 16 cycles.
- Leading zeros: load value=0050h, blank_lz=1 -> digits 3 and 2 show 7Fh, digit 1 shows 12h, digit 0 shows 40h; with value=0000h, only digit 0 shows 40h.
- Decimal point: load dp_in=0100b with value=ABCDh -> dp_n=0 only while an_n=Bh, with seg_n=03h in that slot.
- Enable gap: drop enable for 10 cycles mid-slot -> display dark and frame_done absent for those cycles; on re-enable, the same idx resumes with the remaining prescaler count.
- Load timing and async reset:
  - A load at the last cycle of digit 0's slot shows the new nibbles from the next slot.
  - Asserting rst_n=0 mid-slot clears the outputs within the same cycle.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package ssd_pkg;

    // All segments off (active-low drive).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex font, bit6 = g ... bit0 = a, indexed by nibble value.
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Translate one hex nibble into its active-low segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot prescaler and digit index for the scan driver. The frame tick is
// combinational here; the top level registers it onto the output pin.
module ssd_scan_timer
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int PW          = $clog2(REFRESH_DIV),
    parameter int IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic [PW-1:0] presc_o,
    output logic [IW-1:0] idx_o,
    output logic          frame_tick_o
);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          term_s;

    // Next-state for prescaler and digit index; both freeze while disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        term_s  = (presc_q == PW'(REFRESH_DIV - 1));
        if (enable_i) begin
            if (term_s) begin
                presc_d = '0;
                if (idx_q == IW'(NUM_DIGITS - 1)) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
            idx_d   = idx_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    assign presc_o      = presc_q;
    assign idx_o        = idx_q;
    assign frame_tick_o = enable_i & term_s & (idx_q == IW'(NUM_DIGITS - 1));

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with ghost blanking,
// leading-zero suppression and per-digit decimal points. All pins registered.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    lz_q;

    logic [PW-1:0]           presc_s;
    logic [IW-1:0]           idx_s;
    logic                    frame_tick_s;

    logic [NUM_DIGITS-1:0]   lz_blank_s;
    logic                    zero_run_s;
    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic                    blank_sel_s;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    ssd_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .PW          (PW),
        .IW          (IW)
    ) u_timer (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .presc_o      (presc_s),
        .idx_o        (idx_s),
        .frame_tick_o (frame_tick_s)
    );

    // Shadow registers capture a new display image on load, regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            dp_q  <= '0;
            lz_q  <= 1'b0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp_in;
            lz_q  <= blank_lz;
        end else begin
            val_q <= val_q;
            dp_q  <= dp_q;
            lz_q  <= lz_q;
        end
    end

    // Leading-zero mask: walk from the top digit down while nibbles stay zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_blank_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (val_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz_blank_s[i] = lz_q & zero_run_s;
            end else begin
                lz_blank_s[i] = 1'b0;
            end
        end
    end

    // Pick the nibble, decimal point and blank flag of the digit being scanned.
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_s == IW'(i)) begin
                nib_s       = val_q[4*i +: 4];
                dp_sel_s    = dp_q[i];
                blank_sel_s = lz_blank_s[i];
            end else begin
                nib_s       = nib_s;
            end
        end
    end

    // Next pin values: dark when disabled or inside the anti-ghost window.
    always_comb begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        an_d   = '1;
        fd_d   = 1'b0;
        if (enable) begin
            fd_d = frame_tick_s;
            if (presc_s >= PW'(BLANK_CYCLES)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    an_d[i] = (idx_s != IW'(i));
                end
                dp_n_d = ~dp_sel_s;
                if (blank_sel_s) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = hex_to_seg(nib_s);
                end
            end else begin
                seg_d = SEG_BLANK;
            end
        end else begin
            fd_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
            an_q   <= '1;
            fd_q   <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            an_q   <= an_d;
            fd_q   <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    ssd_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        value    = v;
        dp_in    = dp;
        blank_lz = lz;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Step until frame_done is seen; afterwards the timer sits at slot 0, count 0.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_frame: frame_done not seen within 40 cycles", tag);
        end
    endtask

    // Check 16 cycles of one frame; each slot is 1 dark cycle then 3 lit cycles.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
        logic [6:0] segs [4];
        logic [3:0] one;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        int         slot;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        one = 4'b0001;
        for (int j = 0; j < 16; j++) begin
            step();
            slot = j / 4;
            if ((j % 4) == 0) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = ~(one << slot); e_seg = segs[slot]; e_dp = ~dpm[slot];
            end
            e_fd = (j == 15);
            checks += 4;
            if (an_n !== e_an) begin
                errors++; $display("FAIL %s an_n cyc%0d: got %h exp %h", tag, j, an_n, e_an);
            end
            if (seg_n !== e_seg) begin
                errors++; $display("FAIL %s seg_n cyc%0d: got %h exp %h", tag, j, seg_n, e_seg);
            end
            if (dp_n !== e_dp) begin
                errors++; $display("FAIL %s dp_n cyc%0d: got %b exp %b", tag, j, dp_n, e_dp);
            end
            if (frame_done !== e_fd) begin
                errors++; $display("FAIL %s frame_done cyc%0d: got %b exp %b", tag, j, frame_done, e_fd);
            end
        end
    endtask

    task automatic check_pins(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_fd);
        checks += 4;
        if (an_n !== e_an) begin
            errors++; $display("FAIL %s an_n: got %h exp %h", tag, an_n, e_an);
        end
        if (seg_n !== e_seg) begin
            errors++; $display("FAIL %s seg_n: got %h exp %h", tag, seg_n, e_seg);
        end
        if (dp_n !== e_dp) begin
            errors++; $display("FAIL %s dp_n: got %b exp %b", tag, dp_n, e_dp);
        end
        if (frame_done !== e_fd) begin
            errors++; $display("FAIL %s frame_done: got %b exp %b", tag, frame_done, e_fd);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'($urandom_range(0, 1));
        load     = 1'($urandom_range(0, 1));
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        blank_lz = 1'($urandom_range(0, 1));
        for (int k = 0; k < 3; k++) step();
        check_pins("reset_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        rst_n  = 1'b1;
        step();
        check_pins("reset_first_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check_pins("reset_first_lit", 4'hE, 7'h40, 1'b1, 1'b0);
    endtask

    task automatic test_scan();
        do_load(16'h1234, 4'b0000, 1'b0);
        wait_frame("scan");
        check_frame("scan_f1", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        check_frame("scan_f2", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
    endtask

    task automatic test_leading_zeros();
        do_load(16'h0050, 4'b0000, 1'b1);
        wait_frame("lz50");
        check_frame("lz_0050", 7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0000);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_frame("lz00");
        check_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    endtask

    task automatic test_decimal_point();
        do_load(16'hABCD, 4'b0100, 1'b0);
        wait_frame("dp");
        check_frame("dp_abcd", 7'h21, 7'h46, 7'h03, 7'h08, 4'b0100);
    endtask

    task automatic test_enable_gap();
        do_load(16'h1234, 4'b0000, 1'b0);
        wait_frame("gap");
        step();
        step();
        check_pins("gap_before", 4'hE, 7'h19, 1'b1, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_pins("gap_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        enable = 1'b1;
        step();
        check_pins("gap_resume1", 4'hE, 7'h19, 1'b1, 1'b0);
        step();
        check_pins("gap_resume2", 4'hE, 7'h19, 1'b1, 1'b0);
        step();
        check_pins("gap_next_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check_pins("gap_next_lit", 4'hD, 7'h30, 1'b1, 1'b0);
    endtask

    task automatic test_load_timing();
        do_load(16'h1234, 4'b0000, 1'b0);
        wait_frame("ldt");
        step();
        step();
        step();
        value = 16'h5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check_pins("ldt_old_digit0", 4'hE, 7'h19, 1'b1, 1'b0);
        step();
        check_pins("ldt_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check_pins("ldt_new_digit1", 4'hD, 7'h78, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        check_pins("arst_immediate", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        step();
        check_pins("arst_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        check_pins("arst_first_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check_pins("arst_first_lit", 4'hE, 7'h40, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zeros();
        test_decimal_point();
        test_enable_gap();
        test_load_timing();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
